// File: rtl/serial_cmd_engine.sv
// Byte-command engine between the UART and the trigger/histogram logic.
// Config register file, histogram dump, inter-byte timeout, error counter.
module serial_cmd_engine #(
   parameter int               NCH        = 8,
   parameter int               HW         = 32,
   parameter int               NREG       = 16,
   parameter int               TIMEOUT    = 1000000,
   parameter logic [7:0]       FW_VERSION = 8'd9,
   parameter logic [NREG*8-1:0] CFG_INIT  = '0
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                rx_ready,
   input  logic [7:0]          rx_data,
   input  logic                tx_busy,
   output logic                tx_start,
   output logic [7:0]          tx_data,
   input  logic [NCH*HW-1:0]   histos,
   output logic                reset_hist,
   output logic [NREG*8-1:0]   cfg_regs,
   output logic [NREG-1:0]     cfg_wr,
   output logic [7:0]          err_count
);

   localparam int NB = NCH * HW / 8;
   localparam int IW = $clog2(NB) + 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ARGS, S_EXEC, S_SNAP, S_TX_LOAD, S_TX_GAP
   } state_t;

   state_t              r_state;
   logic [7:0]          r_op;
   logic [7:0]          r_arg0;
   logic [7:0]          r_arg1;
   logic [1:0]          r_argcnt;
   logic [TW-1:0]       r_tmo;
   logic [NCH*HW-1:0]   r_snap;
   logic [IW-1:0]       r_idx;
   logic                r_dump;
   logic [7:0]          r_resp;

   logic                w_addr_ok;
   logic [7:0]          w_rd;
   logic [7:0]          w_byte;
   logic                w_e_exec;
   logic                w_e_tmo;
   logic                w_e_drop;
   logic                w_clr;
   logic [1:0]          w_err_inc;
   logic [7:0]          w_err_base;
   logic [8:0]          w_err_sum;
   logic [7:0]          w_err_nxt;

   function automatic logic [1:0] f_need(input logic [7:0] op);
      if (op == 8'h01) return 2'd2;
      if (op == 8'h02) return 2'd1;
      return 2'd0;
   endfunction

   assign w_addr_ok = 32'(r_arg0) < 32'(NREG);

   // Config readback mux and snapshot byte selector
   always_comb begin
      w_rd   = 8'h00;
      w_byte = 8'h00;
      for (int k = 0; k < NREG; k++)
         if (r_arg0 == 8'(k)) w_rd = cfg_regs[k*8 +: 8];
      for (int b = 0; b < NB; b++)
         if (r_idx == IW'(b)) w_byte = r_snap[b*8 +: 8];
   end

   // Error sources and saturating next error count; an error beats a clear
   always_comb begin
      w_e_exec = (r_state == S_EXEC) &&
                 ((((r_op == 8'h01) || (r_op == 8'h02)) && !w_addr_ok) ||
                  (r_op > 8'h04));
      w_e_tmo  = (r_state == S_ARGS) && !rx_ready &&
                 (r_tmo == TW'(TIMEOUT - 1));
      w_e_drop = rx_ready && (r_state != S_IDLE) && (r_state != S_ARGS);
      w_clr    = (r_state == S_EXEC) && (r_op == 8'h04);
      w_err_inc  = 2'(w_e_exec) + 2'(w_e_tmo) + 2'(w_e_drop);
      w_err_base = w_clr ? 8'h00 : err_count;
      w_err_sum  = {1'b0, w_err_base} + 9'(w_err_inc);
      w_err_nxt  = w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
   end

   // Command FSM with registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_op       <= '0;
         r_arg0     <= '0;
         r_arg1     <= '0;
         r_argcnt   <= '0;
         r_tmo      <= '0;
         r_snap     <= '0;
         r_idx      <= '0;
         r_dump     <= 1'b0;
         r_resp     <= '0;
         tx_start   <= 1'b0;
         tx_data    <= '0;
         reset_hist <= 1'b0;
         cfg_regs   <= CFG_INIT;
         cfg_wr     <= '0;
         err_count  <= '0;
      end else begin
         tx_start   <= 1'b0;
         reset_hist <= 1'b0;
         cfg_wr     <= '0;
         err_count  <= w_err_nxt;
         unique case (r_state)
            S_IDLE: begin
               if (rx_ready) begin
                  r_op     <= rx_data;
                  r_argcnt <= '0;
                  r_tmo    <= '0;
                  r_state  <= (f_need(rx_data) != 2'd0) ? S_ARGS : S_EXEC;
               end
            end
            S_ARGS: begin
               if (rx_ready) begin
                  r_tmo <= '0;
                  if (r_argcnt == 2'd0) r_arg0 <= rx_data;
                  else                  r_arg1 <= rx_data;
                  r_argcnt <= r_argcnt + 2'd1;
                  if (r_argcnt + 2'd1 == f_need(r_op)) r_state <= S_EXEC;
               end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                  r_state <= S_IDLE;
               end else begin
                  r_tmo <= r_tmo + 1'b1;
               end
            end
            S_EXEC: begin
               r_dump  <= 1'b0;
               r_idx   <= '0;
               r_state <= S_TX_LOAD;
               unique case (r_op)
                  8'h00: r_resp <= FW_VERSION;
                  8'h01: begin
                     r_resp <= w_addr_ok ? 8'hA5 : 8'hEE;
                     for (int k = 0; k < NREG; k++)
                        if (r_arg0 == 8'(k)) begin
                           cfg_regs[k*8 +: 8] <= r_arg1;
                           cfg_wr[k]          <= 1'b1;
                        end
                  end
                  8'h02: r_resp <= w_addr_ok ? w_rd : 8'hEE;
                  8'h03: begin
                     r_dump     <= 1'b1;
                     reset_hist <= 1'b1;
                     r_state    <= S_SNAP;
                  end
                  8'h04: r_resp <= err_count;
                  default: r_resp <= 8'hEE;
               endcase
            end
            S_SNAP: begin
               r_snap  <= histos;
               r_state <= S_TX_LOAD;
            end
            S_TX_LOAD: begin
               if (!tx_busy) begin
                  tx_start <= 1'b1;
                  tx_data  <= r_dump ? w_byte : r_resp;
                  r_state  <= S_TX_GAP;
               end
            end
            S_TX_GAP: begin
               if (r_dump && (r_idx != IW'(NB - 1))) begin
                  r_idx   <= r_idx + 1'b1;
                  r_state <= S_TX_LOAD;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_cmd_engine.sv
// Directed bench for serial_cmd_engine: command table, timeout,
// histogram dump, busy stall, saturation and mid-dump reset.
module tb_serial_cmd_engine;

   localparam int NCH  = 8;
   localparam int HW   = 32;
   localparam int NREG = 16;
   localparam logic [127:0] INIT = 128'h00112233_44556677_8899AABB_CCDDEEFF;

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic               rx_ready = 1'b0;
   logic [7:0]         rx_data = '0;
   logic               tx_busy = 1'b0;
   logic               tx_start;
   logic [7:0]         tx_data;
   logic [NCH*HW-1:0]  histos = '0;
   logic               reset_hist;
   logic [NREG*8-1:0]  cfg_regs;
   logic [NREG-1:0]    cfg_wr;
   logic [7:0]         err_count;

   serial_cmd_engine #(
      .NCH(NCH), .HW(HW), .NREG(NREG), .TIMEOUT(100),
      .FW_VERSION(8'd9), .CFG_INIT(INIT)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .rx_ready(rx_ready), .rx_data(rx_data),
      .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
      .histos(histos), .reset_hist(reset_hist),
      .cfg_regs(cfg_regs), .cfg_wr(cfg_wr), .err_count(err_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   logic [7:0] q_tx[$];
   int q_cyc[$];
   int rh_cnt = 0;
   int rh_cyc = 0;
   int wr_cnt = 0;
   logic [15:0] last_wr = '0;
   bit tx_emul = 0;
   int busy_cnt = 0;

   always @(posedge clk) cyc = cyc + 1;

   always @(negedge clk) begin
      if (tx_start) begin
         q_tx.push_back(tx_data);
         q_cyc.push_back(cyc);
      end
      if (reset_hist) begin
         rh_cnt = rh_cnt + 1;
         rh_cyc = cyc;
      end
      if (cfg_wr != '0) begin
         wr_cnt = wr_cnt + 1;
         last_wr = cfg_wr;
      end
   end

   always @(negedge clk) begin
      if (tx_emul) begin
         if (tx_start) begin
            busy_cnt = 6;
            tx_busy = 1'b1;
         end else if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
            if (busy_cnt == 0) tx_busy = 1'b0;
         end
      end
   end

   typedef struct {
      logic [23:0] bytes;
      int          nb;
      logic [7:0]  exp;
      logic [7:0]  err;
      logic [15:0] wr;
   } vec_t;

   vec_t tv[17];
   logic [127:0] m_cfg;

   task automatic chk(input string nm, input logic [255:0] act,
                      input logic [255:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, output int t);
      @(posedge clk);
      #1 rx_ready = 1'b1;
      rx_data = b;
      @(posedge clk);
      #1 rx_ready = 1'b0;
      t = cyc;
   endtask

   task automatic wait_tx(input int n, input int lim, input string nm);
      int k;
      k = 0;
      while (q_tx.size() < n && k < lim) begin
         @(negedge clk);
         k++;
      end
      if (q_tx.size() < n) chk({nm, "_timeout"}, 256'(q_tx.size()), 256'(n));
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] hb(input logic [31:0] base, input int i);
      logic [31:0] w;
      w = base + 32'(i / 4);
      return w[8*(i % 4) +: 8];
   endfunction

   task automatic set_hist(input logic [31:0] base);
      for (int c = 0; c < NCH; c++) histos[c*HW +: HW] = base + 32'(c);
   endtask

   task automatic cmd1(input logic [7:0] op, input logic [7:0] exp,
                       input string nm);
      int t;
      q_tx.delete();
      q_cyc.delete();
      send(op, t);
      wait_tx(1, 40, nm);
      chk({nm, "_data"}, 256'(q_tx[0]), 256'(exp));
      chk({nm, "_lat"}, 256'(q_cyc[0]), 256'(t + 2));
      idle(2);
   endtask

   initial begin
      int t;
      int n;
      int k;
      int rh0;
      int wr0;
      m_cfg = INIT;
      tv[0]  = '{24'h000000, 1, 8'h09, 8'd0, 16'h0000};
      tv[1]  = '{24'h01035A, 3, 8'hA5, 8'd0, 16'h0008};
      tv[2]  = '{24'h020300, 2, 8'h5A, 8'd0, 16'h0000};
      tv[3]  = '{24'h012011, 3, 8'hEE, 8'd1, 16'h0000};
      tv[4]  = '{24'h020300, 2, 8'h5A, 8'd1, 16'h0000};
      tv[5]  = '{24'h022000, 2, 8'hEE, 8'd2, 16'h0000};
      tv[6]  = '{24'h010F77, 3, 8'hA5, 8'd2, 16'h8000};
      tv[7]  = '{24'h020F00, 2, 8'h77, 8'd2, 16'h0000};
      tv[8]  = '{24'h011066, 3, 8'hEE, 8'd3, 16'h0000};
      tv[9]  = '{24'h020000, 2, 8'hFF, 8'd3, 16'h0000};
      tv[10] = '{24'h040000, 1, 8'h03, 8'd0, 16'h0000};
      tv[11] = '{24'h770000, 1, 8'hEE, 8'd1, 16'h0000};
      tv[12] = '{24'h770000, 1, 8'hEE, 8'd2, 16'h0000};
      tv[13] = '{24'h770000, 1, 8'hEE, 8'd3, 16'h0000};
      tv[14] = '{24'h040000, 1, 8'h03, 8'd0, 16'h0000};
      tv[15] = '{24'h040000, 1, 8'h00, 8'd0, 16'h0000};
      tv[16] = '{24'h000000, 1, 8'h09, 8'd0, 16'h0000};

      idle(3);
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_tx_start", 256'(tx_start), 256'(0));
      chk("rst_tx_data", 256'(tx_data), 256'(0));
      chk("rst_reset_hist", 256'(reset_hist), 256'(0));
      chk("rst_cfg_wr", 256'(cfg_wr), 256'(0));
      chk("rst_err", 256'(err_count), 256'(0));
      chk("rst_cfg", 256'(cfg_regs), 256'(INIT));

      for (int v = 0; v < 17; v++) begin
         q_tx.delete();
         q_cyc.delete();
         wr0 = wr_cnt;
         for (int j = 0; j < tv[v].nb; j++) send(tv[v].bytes[23-8*j -: 8], t);
         wait_tx(1, 40, $sformatf("v%0d", v));
         chk($sformatf("v%0d_data", v), 256'(q_tx[0]), 256'(tv[v].exp));
         chk($sformatf("v%0d_lat", v), 256'(q_cyc[0]), 256'(t + 2));
         chk($sformatf("v%0d_err", v), 256'(err_count), 256'(tv[v].err));
         chk($sformatf("v%0d_wrcnt", v), 256'(wr_cnt - wr0),
             256'(tv[v].wr != 0));
         if (tv[v].wr != 0) begin
            chk($sformatf("v%0d_wr", v), 256'(last_wr), 256'(tv[v].wr));
            m_cfg[int'(tv[v].bytes[15:8])*8 +: 8] = tv[v].bytes[7:0];
         end
         chk($sformatf("v%0d_cfg", v), 256'(cfg_regs), 256'(m_cfg));
         idle(2);
      end

      q_tx.delete();
      send(8'h01, t);
      send(8'h02, t);
      idle(90);
      chk("tmo_early_err", 256'(err_count), 256'(0));
      idle(20);
      chk("tmo_err", 256'(err_count), 256'(1));
      chk("tmo_no_tx", 256'(q_tx.size()), 256'(0));
      cmd1(8'h00, 8'h09, "tmo_next");

      q_tx.delete();
      q_cyc.delete();
      send(8'h00, t);
      send(8'h55, n);
      wait_tx(1, 40, "drop");
      chk("drop_data", 256'(q_tx[0]), 256'(8'h09));
      chk("drop_lat", 256'(q_cyc[0]), 256'(t + 2));
      idle(4);
      chk("drop_err", 256'(err_count), 256'(2));
      cmd1(8'h04, 8'h02, "clr");

      set_hist(32'h11223300);
      q_tx.delete();
      q_cyc.delete();
      rh0 = rh_cnt;
      send(8'h03, t);
      k = 0;
      while (rh_cnt == rh0 && k < 10) begin
         @(negedge clk);
         k++;
      end
      @(posedge clk);
      #1 set_hist(32'hDEADBEEF);
      wait_tx(32, 200, "dump");
      idle(10);
      chk("dump_n", 256'(q_tx.size()), 256'(32));
      chk("dump_rh_cnt", 256'(rh_cnt - rh0), 256'(1));
      chk("dump_rh_cyc", 256'(rh_cyc), 256'(t + 1));
      chk("dump_lat", 256'(q_cyc[0]), 256'(t + 3));
      for (int i = 0; i < 32; i++)
         chk($sformatf("dump_b%0d", i), 256'(q_tx[i]),
             256'(hb(32'h11223300, i)));

      for (int i = 0; i < 300; i++) begin
         q_tx.delete();
         send(8'h77, t);
         wait_tx(1, 40, "sat");
         idle(2);
         if (i == 254) chk("sat_255", 256'(err_count), 256'(255));
      end
      chk("sat_hold", 256'(err_count), 256'(255));

      set_hist(32'h80706000);
      tx_busy = 1'b1;
      q_tx.delete();
      send(8'h03, t);
      idle(30);
      chk("busy_stall", 256'(q_tx.size()), 256'(0));
      tx_busy = 1'b0;
      tx_emul = 1;
      wait_tx(32, 800, "busy");
      idle(20);
      chk("busy_n", 256'(q_tx.size()), 256'(32));
      for (int i = 0; i < 32; i++)
         chk($sformatf("busy_b%0d", i), 256'(q_tx[i]),
             256'(hb(32'h80706000, i)));

      q_tx.delete();
      send(8'h03, t);
      n = 0;
      k = 0;
      while (n < 11 && k < 400) begin
         @(negedge clk);
         if (tx_start) n++;
         k++;
      end
      chk("mid_txs", 256'(tx_start), 256'(1));
      #1 reset_n = 1'b0;
      #1;
      chk("mid_rst_txs", 256'(tx_start), 256'(0));
      chk("mid_rst_txd", 256'(tx_data), 256'(0));
      chk("mid_rst_cfg", 256'(cfg_regs), 256'(INIT));
      chk("mid_rst_err", 256'(err_count), 256'(0));
      tx_emul = 0;
      tx_busy = 1'b0;
      idle(2);
      reset_n = 1'b1;
      idle(2);
      cmd1(8'h00, 8'h09, "post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
